// File: rtl/pb_pkg.sv
// Shared types and helpers for the pushbutton debouncer.
// Holds the auto-repeat state encoding and the counter-width rule.
package pb_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_e;

  // Bits needed to hold 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pb_debounce_ch.sv
// One debounced button channel: stability counter, debounced level, edge pulses
// and the hold auto-repeat state machine, all advanced by the shared sample tick.
module pb_debounce_ch
  import pb_pkg::*;
#(
  parameter int STABLE_SAMPLES = 8,
  parameter int REPEAT_EN      = 1,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sample,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int SW = cnt_width(STABLE_SAMPLES - 1);

  logic [SW-1:0] stable_cnt;
  logic          flip;
  logic          press_now;
  logic          release_now;

  // The level flips on the tick that completes a full run of differing samples.
  assign flip        = tick && (sample != level) && (stable_cnt == SW'(STABLE_SAMPLES - 1));
  assign press_now   = flip && sample;
  assign release_now = flip && !sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt    <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= press_now;
      release_pulse <= release_now;
      if (tick) begin
        if (sample == level || flip) begin
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end
        if (flip) begin
          level <= sample;
        end
      end
    end
  end

  generate
    if (REPEAT_EN != 0) begin : g_repeat
      localparam int RW = cnt_width(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) - 1);

      rpt_state_e    state;
      logic [RW-1:0] rcnt;

      // A release on the same clock as a due repeat suppresses that repeat.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state        <= RPT_IDLE;
          rcnt         <= '0;
          repeat_pulse <= 1'b0;
        end else begin
          repeat_pulse <= 1'b0;
          if (release_now) begin
            state <= RPT_IDLE;
            rcnt  <= '0;
          end else if (press_now) begin
            state <= RPT_DELAY;
            rcnt  <= '0;
          end else if (tick && level) begin
            case (state)
              RPT_DELAY: begin
                if (rcnt == RW'(REPEAT_DELAY - 1)) begin
                  repeat_pulse <= 1'b1;
                  state        <= RPT_REPEAT;
                  rcnt         <= '0;
                end else begin
                  rcnt <= rcnt + 1'b1;
                end
              end
              RPT_REPEAT: begin
                if (rcnt == RW'(REPEAT_RATE - 1)) begin
                  repeat_pulse <= 1'b1;
                  rcnt         <= '0;
                end else begin
                  rcnt <= rcnt + 1'b1;
                end
              end
              default: begin
                state <= RPT_IDLE;
                rcnt  <= '0;
              end
            endcase
          end
        end
      end
    end else begin : g_no_repeat
      assign repeat_pulse = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/pb_debounce_multi.sv
// N-channel pushbutton debouncer: reset release synchronizer, shared sample-tick
// divider and per-channel 2-FF input synchronizers feeding one channel block each.
module pb_debounce_multi
  import pb_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int TICK_DIV       = 100000,
  parameter int STABLE_SAMPLES = 8,
  parameter int REPEAT_EN      = 1,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  localparam int DW = cnt_width(TICK_DIV - 1);

  logic [1:0]      rst_pipe;
  logic            rst_int_n;
  logic [DW-1:0]   div_cnt;
  logic            tick;
  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;

  // Reset asserts asynchronously everywhere but is released on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= '0;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_int_n = rst_pipe[1];
  assign tick      = (div_cnt == DW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      div_cnt <= '0;
      sync1   <= '0;
      sync2   <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      sync1   <= button;
      sync2   <= sync1;
    end
  end

  generate
    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
      pb_debounce_ch #(
        .STABLE_SAMPLES(STABLE_SAMPLES),
        .REPEAT_EN     (REPEAT_EN),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_RATE   (REPEAT_RATE)
      ) u_ch (
        .clk          (clk),
        .rst_n        (rst_int_n),
        .tick         (tick),
        .sample       (sync2[ch]),
        .level        (level[ch]),
        .press_pulse  (press_pulse[ch]),
        .release_pulse(release_pulse[ch]),
        .repeat_pulse (repeat_pulse[ch])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pb_debounce_multi.sv
// Self-checking bench for pb_debounce_multi: directed scenarios plus random button
// activity, all outputs compared every cycle against a window/arithmetic reference model.
module tb_pb_debounce_multi;

  localparam int NCH = 2;
  localparam int TDIV = 4;
  localparam int SS = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [NCH-1:0] button = '0;
  logic [NCH-1:0] level;
  logic [NCH-1:0] press_pulse;
  logic [NCH-1:0] release_pulse;
  logic [NCH-1:0] repeat_pulse;

  int n_compared = 0;
  int n_mismatch = 0;

  pb_debounce_multi #(
    .N_CH          (NCH),
    .TICK_DIV      (TDIV),
    .STABLE_SAMPLES(SS),
    .REPEAT_EN     (1),
    .REPEAT_DELAY  (RD),
    .REPEAT_RATE   (RR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .button       (button),
    .level        (level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] required);
    n_compared++;
    if (observed !== required) begin
      n_mismatch++;
      $display("[TB] FAIL %s: observed=%0h required=%0h at %0t", tag, observed, required, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] btn, input int cycles);
    @(negedge clk);
    button = btn;
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic pulseReset(input int cycles);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Reference model: level flips once the last SS tick samples all differ from it;
  // repeats fall on held-tick counts RD, RD+RR, RD+2RR, ...
  logic [NCH-1:0] exp_level = '0;
  logic [NCH-1:0] exp_press = '0;
  logic [NCH-1:0] exp_release = '0;
  logic [NCH-1:0] exp_repeat = '0;
  logic [NCH-1:0] sync_q[$];
  logic [NCH-1:0] win[$];
  int             active_cnt = 0;
  int             clk_count = 0;
  int             since_flip[NCH];
  int             held_ticks[NCH];

  always @(posedge clk) begin
    logic [NCH-1:0] synced;
    bit             flip;
    exp_press   = '0;
    exp_release = '0;
    exp_repeat  = '0;
    if (!rst_n) begin
      active_cnt = 0;
      clk_count  = 0;
      exp_level  = '0;
      sync_q     = '{'0, '0};
      win.delete();
      for (int c = 0; c < NCH; c++) begin
        since_flip[c] = 0;
        held_ticks[c] = 0;
      end
    end else if (active_cnt < 2) begin
      active_cnt++;
    end else begin
      synced = sync_q.pop_front();
      sync_q.push_back(button);
      if (clk_count % TDIV == TDIV - 1) begin
        win.push_back(synced);
        if (win.size() > SS) void'(win.pop_front());
        for (int c = 0; c < NCH; c++) begin
          since_flip[c]++;
          if (exp_level[c]) held_ticks[c]++;
          flip = (since_flip[c] >= SS);
          if (flip) begin
            for (int k = 0; k < SS; k++) begin
              if (win[win.size() - 1 - k][c] == exp_level[c]) flip = 0;
            end
          end
          if (flip) begin
            since_flip[c] = 0;
            if (exp_level[c]) begin
              exp_release[c] = 1'b1;
              exp_level[c]   = 1'b0;
            end else begin
              exp_press[c]  = 1'b1;
              exp_level[c]  = 1'b1;
              held_ticks[c] = 0;
            end
          end else if (exp_level[c] && held_ticks[c] >= RD && (held_ticks[c] - RD) % RR == 0) begin
            exp_repeat[c] = 1'b1;
          end
        end
      end
      clk_count++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_level", 32'(level), 32'd0);
      checkOutput("rst_press", 32'(press_pulse), 32'd0);
      checkOutput("rst_release", 32'(release_pulse), 32'd0);
      checkOutput("rst_repeat", 32'(repeat_pulse), 32'd0);
    end else begin
      checkOutput("level", 32'(level), 32'(exp_level));
      checkOutput("press", 32'(press_pulse), 32'(exp_press));
      checkOutput("release", 32'(release_pulse), 32'(exp_release));
      checkOutput("repeat", 32'(repeat_pulse), 32'(exp_repeat));
    end
  end

  int first_at, rep1, rep2, cnt_a, cnt_b, cnt_c;
  bit seen;
  logic [NCH-1:0] first_val;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(2'b11, 40);

    $display("[TB] test 1: async reset mid-run");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t1_level", 32'(level), 32'd0);
    checkOutput("t1_press", 32'(press_pulse), 32'd0);
    checkOutput("t1_repeat", 32'(repeat_pulse), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(2'b00, 30);

    $display("[TB] test 2: clean press on ch0");
    @(negedge clk);
    button = 2'b01;
    first_at = -1;
    cnt_a = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (press_pulse[0]) begin
        cnt_a++;
        if (first_at < 0) first_at = i;
      end
      if (level[1]) cnt_b++;
    end
    checkOutput("t2_press_in_time", 32'((first_at > 0) && (first_at <= 2 + SS * TDIV + TDIV)), 32'd1);
    checkOutput("t2_press_count", 32'(cnt_a), 32'd1);
    checkOutput("t2_level0", 32'(level[0]), 32'd1);
    checkOutput("t2_level1", 32'(level[1]), 32'd0);
    applyStimulus(2'b00, 40);

    $display("[TB] test 3: two-tick glitch on ch0");
    applyStimulus(2'b01, 2 * TDIV);
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
    @(negedge clk);
    button = 2'b00;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (press_pulse[0]) cnt_a++;
      if (release_pulse[0]) cnt_b++;
      if (level[0]) cnt_c++;
    end
    checkOutput("t3_press_count", 32'(cnt_a), 32'd0);
    checkOutput("t3_release_count", 32'(cnt_b), 32'd0);
    checkOutput("t3_level_high_cycles", 32'(cnt_c), 32'd0);

    $display("[TB] test 4: hold ch0 for auto-repeat");
    @(negedge clk);
    button = 2'b01;
    first_at = -1;
    rep1 = -1;
    rep2 = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (press_pulse[0] && first_at < 0) first_at = i;
      if (repeat_pulse[0]) begin
        if (rep1 < 0) rep1 = i;
        else if (rep2 < 0) rep2 = i;
      end
    end
    checkOutput("t4_first_repeat_gap", 32'(rep1 - first_at), 32'(RD * TDIV));
    checkOutput("t4_repeat_period", 32'(rep2 - rep1), 32'(RR * TDIV));
    @(negedge clk);
    button = 2'b00;
    seen = 0;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (seen && repeat_pulse[0]) cnt_b++;
      if (release_pulse[0]) begin
        cnt_a++;
        seen = 1;
      end
    end
    checkOutput("t4_release_count", 32'(cnt_a), 32'd1);
    checkOutput("t4_repeat_after_release", 32'(cnt_b), 32'd0);

    $display("[TB] test 5: both channels together");
    @(negedge clk);
    button = 2'b11;
    first_val = '0;
    for (int i = 0; i < 24 && first_val == '0; i++) begin
      @(negedge clk);
      first_val = press_pulse;
    end
    checkOutput("t5_press_both", 32'(first_val), 32'd3);
    applyStimulus(2'b11, 20);
    @(negedge clk);
    button = 2'b01;
    first_val = '0;
    cnt_a = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (first_val == '0) first_val = release_pulse;
      if (first_val != '0 && repeat_pulse[0]) cnt_a++;
    end
    checkOutput("t5_release_ch1_only", 32'(first_val), 32'd2);
    checkOutput("t5_ch0_repeats_continue", 32'(cnt_a > 0), 32'd1);
    checkOutput("t5_level", 32'(level), 32'd1);

    $display("[TB] test 6: reset while ch0 held");
    pulseReset(3);
    first_at = -1;
    cnt_a = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (release_pulse != '0) cnt_a++;
      if (press_pulse[0] && first_at < 0) first_at = i;
    end
    checkOutput("t6_no_release", 32'(cnt_a), 32'd0);
    checkOutput("t6_press_again", 32'(first_at > 0), 32'd1);

    $display("[TB] random phase");
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) pulseReset($urandom_range(1, 4));
      applyStimulus(NCH'($urandom_range(0, 3)), $urandom_range(1, 45));
    end
    applyStimulus(2'b00, 40);
    checkOutput("final_level", 32'(level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
